// File: rtl/can_tx_bitstream.sv
// Bit-level CAN transmitter: drives one frame bit per bit time, inserts stuff bits,
// and monitors the bus at each sample point for arbitration loss and bit errors.
module can_tx_bitstream #(
    parameter int STUFF_LEN = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_point,
    input  logic sample_point,
    input  logic rx,
    input  logic in_bit,
    input  logic in_stuff,
    input  logic in_arb,
    input  logic in_nomon,
    input  logic in_last,
    input  logic in_valid,
    output logic in_ready,
    output logic can_tx,
    output logic busy,
    output logic done,
    output logic arb_lost,
    output logic bit_err,
    output logic underrun
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state, state_nx;
    logic [2:0] run, run_nx;
    logic       prev_bit, prev_nx;
    logic       last_sent, last_nx;
    logic       sampled, sampled_nx;
    logic       cur_arb, cur_arb_nx;
    logic       cur_nomon, cur_nomon_nx;
    logic       can_tx_nx, busy_nx;
    logic       done_nx, arb_nx, err_nx, und_nx;
    logic       stuff_pending;
    logic       drive, drv_bit, drv_stuffed;
    logic       mon_exit, tx_exit;

    assign stuff_pending = (run == 3'(STUFF_LEN));
    assign in_ready = tx_point && !stuff_pending && (state == IDLE || !last_sent);

    always_comb begin
        state_nx     = state;
        run_nx       = run;
        prev_nx      = prev_bit;
        last_nx      = last_sent;
        sampled_nx   = sampled;
        cur_arb_nx   = cur_arb;
        cur_nomon_nx = cur_nomon;
        can_tx_nx    = can_tx;
        busy_nx      = busy;
        done_nx      = 1'b0;
        arb_nx       = 1'b0;
        err_nx       = 1'b0;
        und_nx       = 1'b0;
        drive        = 1'b0;
        drv_bit      = 1'b1;
        drv_stuffed  = 1'b0;
        mon_exit     = 1'b0;
        tx_exit      = 1'b0;

        // Sample is evaluated before transmit so an abort or completion wins the cycle
        if (state == SEND && sample_point && !sampled) begin
            if (!cur_nomon && can_tx && !rx) begin
                arb_nx   = cur_arb;
                err_nx   = !cur_arb;
                mon_exit = 1'b1;
            end else if (!cur_nomon && !can_tx && rx) begin
                err_nx   = 1'b1;
                mon_exit = 1'b1;
            end else begin
                sampled_nx = 1'b1;
                if (last_sent && !stuff_pending) begin
                    done_nx  = 1'b1;
                    mon_exit = 1'b1;
                end
            end
        end

        if (!mon_exit && tx_point) begin
            if (state == IDLE) begin
                if (in_valid) begin
                    drive        = 1'b1;
                    drv_bit      = in_bit;
                    drv_stuffed  = in_stuff;
                    cur_arb_nx   = in_arb;
                    cur_nomon_nx = in_nomon;
                    last_nx      = in_last;
                    state_nx     = SEND;
                end
            end else if (stuff_pending) begin
                drive        = 1'b1;
                drv_bit      = ~prev_bit;
                drv_stuffed  = 1'b1;
                cur_arb_nx   = 1'b0;
                cur_nomon_nx = 1'b0;
            end else if (in_valid && in_ready) begin
                drive        = 1'b1;
                drv_bit      = in_bit;
                drv_stuffed  = in_stuff;
                cur_arb_nx   = in_arb;
                cur_nomon_nx = in_nomon;
                last_nx      = in_last;
            end else if (!last_sent) begin
                und_nx  = 1'b1;
                tx_exit = 1'b1;
            end
        end

        if (drive) begin
            can_tx_nx  = drv_bit;
            busy_nx    = 1'b1;
            sampled_nx = 1'b0;
            if (drv_stuffed) begin
                run_nx  = (drv_bit == prev_bit && run != 3'd0) ? run + 3'd1 : 3'd1;
                prev_nx = drv_bit;
            end else begin
                run_nx = 3'd0;
            end
        end

        if (mon_exit || tx_exit) begin
            state_nx   = IDLE;
            can_tx_nx  = 1'b1;
            busy_nx    = 1'b0;
            run_nx     = 3'd0;
            last_nx    = 1'b0;
            sampled_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run       <= 3'd0;
            prev_bit  <= 1'b0;
            last_sent <= 1'b0;
            sampled   <= 1'b0;
            cur_arb   <= 1'b0;
            cur_nomon <= 1'b0;
            can_tx    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            arb_lost  <= 1'b0;
            bit_err   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nx;
            run       <= run_nx;
            prev_bit  <= prev_nx;
            last_sent <= last_nx;
            sampled   <= sampled_nx;
            cur_arb   <= cur_arb_nx;
            cur_nomon <= cur_nomon_nx;
            can_tx    <= can_tx_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            arb_lost  <= arb_nx;
            bit_err   <= err_nx;
            underrun  <= und_nx;
        end
    end

endmodule

// File: tb/tb_can_tx_bitstream.sv
// Directed bench for can_tx_bitstream: each bit time is a tx_point, a sample_point
// two cycles later, and settle cycles; rx is either looped from can_tx or forced.
module tb_can_tx_bitstream;

    logic clk = 1'b0;
    logic rst_n, tx_point, sample_point, rx, rx_loop, rx_force;
    logic in_bit, in_stuff, in_arb, in_nomon, in_last, in_valid;
    logic in_ready, can_tx, busy, done, arb_lost, bit_err, underrun;

    int checks = 0;
    int failures = 0;
    int pulse_count = 0;
    int multi_count = 0;
    int pc_before;

    logic rdy_seen, tx_seen, busy_seen, und_seen;
    logic done_seen, arb_seen, err_seen, tx_after, busy_after;

    logic exp_tx [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    assign rx = rx_loop ? can_tx : rx_force;

    can_tx_bitstream #(.STUFF_LEN(5)) dut (
        .clk(clk), .rst_n(rst_n), .tx_point(tx_point), .sample_point(sample_point),
        .rx(rx), .in_bit(in_bit), .in_stuff(in_stuff), .in_arb(in_arb),
        .in_nomon(in_nomon), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .can_tx(can_tx), .busy(busy), .done(done),
        .arb_lost(arb_lost), .bit_err(bit_err), .underrun(underrun)
    );

    always @(negedge clk) begin
        if (done | arb_lost | bit_err | underrun) pulse_count++;
        if ((int'(done) + int'(arb_lost) + int'(bit_err) + int'(underrun)) > 1) multi_count++;
    end

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One full bit time; entered and left at posedge+1
    task automatic applyStimulus(input logic b, input logic st, input logic ar,
                                 input logic nm, input logic ls, input logic vl);
        in_bit = b; in_stuff = st; in_arb = ar; in_nomon = nm; in_last = ls;
        in_valid = vl; tx_point = 1'b1;
        #1 rdy_seen = in_ready;
        @(posedge clk); #1;
        tx_point = 1'b0; in_valid = 1'b0;
        tx_seen = can_tx; busy_seen = busy; und_seen = underrun;
        @(posedge clk); #1;
        sample_point = 1'b1;
        @(posedge clk); #1;
        sample_point = 1'b0;
        done_seen = done; arb_seen = arb_lost; err_seen = bit_err;
        tx_after = can_tx; busy_after = busy;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; tx_point = 1'b0; sample_point = 1'b0;
        rx_loop = 1'b1; rx_force = 1'b1;
        in_bit = 1'b0; in_stuff = 1'b0; in_arb = 1'b0; in_nomon = 1'b0;
        in_last = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_can_tx", can_tx, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_pulses", done | arb_lost | bit_err | underrun, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Six stuffed zeros: stuff 1 after the fifth, sixth data bit delayed
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("stuff0_rdy%0d", i), rdy_seen, exp_rdy[i]);
            checkOutput($sformatf("stuff0_tx%0d", i), tx_seen, exp_tx[i]);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("f1_done", done_seen, 1'b1);
        checkOutput("f1_busy_after", busy_after, 1'b0);

        // Five stuffed ones then an unstuffed last bit: stuff 0 goes first
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("ones_tx%0d", i), tx_seen, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("f2_stuff_rdy", rdy_seen, 1'b0);
        checkOutput("f2_stuff_tx", tx_seen, 1'b0);
        checkOutput("f2_stuff_nodone", done_seen, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("f2_last_rdy", rdy_seen, 1'b1);
        checkOutput("f2_last_tx", tx_seen, 1'b1);
        checkOutput("f2_done", done_seen, 1'b1);
        checkOutput("f2_tx_after", tx_after, 1'b1);
        checkOutput("f2_busy_after", busy_after, 1'b0);

        // Arbitration loss on a recessive arb bit
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rx_loop = 1'b0; rx_force = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        rx_loop = 1'b1;
        checkOutput("arb_tx", tx_seen, 1'b1);
        checkOutput("arb_lost", arb_seen, 1'b1);
        checkOutput("arb_no_err", err_seen, 1'b0);
        checkOutput("arb_busy_after", busy_after, 1'b0);

        // Dominant non-arb bit read back recessive
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rx_loop = 1'b0; rx_force = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rx_loop = 1'b1;
        checkOutput("err_bit_err", err_seen, 1'b1);
        checkOutput("err_no_arb", arb_seen, 1'b0);
        checkOutput("err_tx_after", tx_after, 1'b1);
        checkOutput("err_busy_after", busy_after, 1'b0);

        // ACK slot overwritten dominant is not an error
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rx_loop = 1'b0; rx_force = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rx_loop = 1'b1;
        checkOutput("ack_no_err", err_seen | arb_seen, 1'b0);
        checkOutput("ack_busy", busy_after, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("ack_done", done_seen, 1'b1);

        // Underrun, then a fresh frame must restart run counting
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("und_pulse", und_seen, 1'b1);
        checkOutput("und_tx", tx_seen, 1'b1);
        checkOutput("und_busy", busy_seen, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("fresh_rdy%0d", i), rdy_seen, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("fresh_stuff_rdy", rdy_seen, 1'b0);
        checkOutput("fresh_stuff_tx", tx_seen, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("fresh_done", done_seen, 1'b1);

        checkOutput("pulse_total", logic'(pulse_count == 7), 1'b1);

        // Asynchronous reset in the middle of the third bit
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        in_bit = 1'b0; in_stuff = 1'b1; in_last = 1'b0; in_valid = 1'b1; tx_point = 1'b1;
        @(posedge clk); #1;
        tx_point = 1'b0; in_valid = 1'b0;
        checkOutput("rst_pre_tx", can_tx, 1'b0);
        checkOutput("rst_pre_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_tx", can_tx, 1'b1);
        checkOutput("rst_async_busy", busy, 1'b0);
        pc_before = pulse_count;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("post_rst_tx%0d", i), tx_after, 1'b1);
        end
        checkOutput("post_rst_no_pulse", logic'(pulse_count == pc_before), 1'b1);
        checkOutput("single_pulse", logic'(multi_count == 0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/can_tx_bitstream.md
# can_tx_bitstream

Bit-level CAN transmitter that sits between the frame builder and the bus pin, paced by the bit-timing block's `tx_point`/`sample_point` strobes. It accepts one frame bit per bit time over a valid/ready handshake and inserts stuff bits. At each sample point it monitors the bus, reporting arbitration loss, bit errors, underrun and frame completion as one-cycle pulses.

## Interface
- `STUFF_LEN`, 5: number of equal consecutive bits after which a complementary stuff bit is inserted.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_point` in 1: one-cycle strobe, start of bit time; drive the next bit.
- `sample_point` in 1: one-cycle strobe, bus sample instant of the current bit.
- `rx` in 1: bus level, already synchronised to `clk` (0 = dominant).
- `in_bit` in 1: frame bit to send.
- `in_stuff` in 1: bit lies in the stuffed region (SOF through CRC).
- `in_arb` in 1: bit lies in the arbitration field.
- `in_nomon` in 1: bit exempt from monitoring (ACK slot).
- `in_last` in 1: final bit of the frame.
- `in_valid` in 1: upstream bit and flags valid.
- `in_ready` out 1: combinational; bit accepted this cycle when `in_valid && in_ready`.
- `can_tx` out 1: registered bus drive (1 = recessive).
- `busy` out 1: frame in progress.
- `done` out 1: pulse, frame finished cleanly.
- `arb_lost` out 1: pulse, arbitration lost.
- `bit_err` out 1: pulse, monitored bit mismatch.
- `underrun` out 1: pulse, no bit available mid-frame.

## Operation
- States: IDLE, SEND.
- `in_ready` = `tx_point && !stuff_pending && (state==IDLE || state==SEND && !last_sent)`.
- IDLE: `can_tx`=1. On a handshake, latch the bit and flags, drive `in_bit`, enter SEND, `busy`=1. If `in_valid`=0 at `tx_point`, stay in IDLE.
- SEND, at `tx_point`, first matching rule wins:
  - `stuff_pending`: drive `~prev_bit`, mark the current bit as stuff (monitored, never arb).
  - Handshake: drive `in_bit` with its flags.
  - `last_sent` (last bit already driven and sampled) is handled at sample, below.
  - `in_valid`=0: `underrun` pulse, go to IDLE, `can_tx`=1.
- Run tracking, 3-bit counter `run` plus `prev_bit`:
  - Driven bit with `in_stuff`=1, or a stuff bit: `run` = (bit==`prev_bit` && `run`≠0) ? `run`+1 : 1; `prev_bit` = bit.
  - Driven bit with `in_stuff`=0: `run`=0.
  - `stuff_pending` = (`run`==`STUFF_LEN`). A pending stuff bit after the final stuffed bit is inserted before the next unstuffed bit.
- Monitor, at `sample_point` in SEND when the current bit has not yet been sampled:
  - `can_tx`=1, `rx`=0, arb bit (not stuff): `arb_lost`, go to IDLE.
  - `can_tx`=1, `rx`=0, non-arb and `!in_nomon`: `bit_err`, go to IDLE.
  - `can_tx`=0, `rx`=1: `bit_err`, go to IDLE.
  - `in_nomon` bits are never errors.
  - Clean sample of an `in_last` bit with no `stuff_pending`: `done`, go to IDLE.
- If a resync produces `tx_point` before `sample_point` of the current bit, the bit advances without a monitor check.
- `sample_point` and `tx_point` in the same cycle: sample is processed first. An error or `done` suppresses the transmit action.
- Every exit to IDLE clears `run`, `busy` and `stuff_pending`.

## Timing
- Reset values: `can_tx`=1; `busy`, `done`, `arb_lost`, `bit_err`, `underrun` all 0; `run`=0; state IDLE.
- `in_ready` is high only in `tx_point` cycles. The handshake in cycle T gives `can_tx` the new value at T+1.
- A stuff bit appears at T+1 of its `tx_point`, with `in_ready` held low that cycle.
- Status pulses are registered and one cycle wide, at T+1 of the deciding `sample_point`.
- On any exit to IDLE: `can_tx`=1 and `busy`=0 at T+1.
- At most one status pulse per cycle.
- `rst_n` low mid-frame: all outputs return to reset values immediately; the frame is discarded and upstream must restart.

## Test plan
- Six stuffed 0 bits, `rx` looped to `can_tx` -> `can_tx` sequence 0,0,0,0,0,1,0. `in_ready` is low at the 6th `tx_point`, and the 6th data bit goes out one bit time late.
- Stuffed 1,1,1,1,1 (last stuffed bit), then an unstuffed `in_last` 1 -> stuff 0 inserted before the last bit. `done` at T+1 of the last sample; `can_tx`=1, `busy`=0.
- Arb bit 1, `rx` forced 0 at `sample_point` -> `arb_lost` pulse, `can_tx`=1 next cycle, no `bit_err`.
- Non-arb 0 with `rx`=1 -> `bit_err` pulse, IDLE. ACK slot (`in_nomon`) 1 with `rx`=0 -> no error, and the frame completes with `done`.
- `in_valid` dropped mid-frame at `tx_point` -> `underrun` pulse, `can_tx`=1. Next frame starts cleanly with `run`=0.
- `rst_n` asserted during bit 3 -> `can_tx`=1 and `busy`=0 without waiting for a clock edge; no pulses after release.
